// File: rtl/led_bank_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// led_bank_arbiter_pkg
// Shared definitions for the LED bank arbiter and its companions:
//   - LED_W_DEFAULT / NUM_REQ_DEFAULT : default bank width and requester count
//   - arb_state_e                     : arbiter state encoding (IDLE/OWNED/GAP)
// The encoding is fixed so that the debug state port can be decoded by tools
// and checkers without reference to the RTL; 2'd3 is illegal.
// ---------------------------------------------------------------------------
package led_bank_arbiter_pkg;

  localparam int LED_W_DEFAULT   = 6;
  localparam int NUM_REQ_DEFAULT = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWNED = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen
// Free-running prescaler producing a 1-cycle tick enable every DIV clocks.
// This is a clock enable, not a derived clock; every LED block that needs a
// slow time base shares this generator.
//
// Parameters:
//   DIV   clocks per tick (>= 2); counter width $clog2(DIV)
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous, active-low reset (counter and tick cleared)
//   tick   out  registered, high for the one cycle after the counter wraps
//
// After reset release the first tick is visible DIV cycles later.
// ---------------------------------------------------------------------------
module led_tick_gen #(
  parameter int DIV = 10000000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= (count == LAST);
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// ---------------------------------------------------------------------------
// led_bank_arbiter
// Shares one LED bank between NUM_REQ status sources. One owner at a time is
// chosen by fixed priority (index 0 highest). An owner keeps the bank for at
// least MIN_HOLD ticks before a higher-priority source may preempt it, and
// every change of owner passes through BLANK_TICKS ticks of all-off gap.
//
// Parameters:
//   NUM_REQ      number of requesters, index 0 = highest priority
//   LED_W        LED bank width
//   TICK_DIV     clocks per tick (>= 2)
//   MIN_HOLD     ticks guaranteed to an owner before preemption (0 = none)
//   BLANK_TICKS  ticks of all-off gap between owners (>= 1)
//   MAX_HOLD     ticks before forced rotation (LED_ARB_TIMEOUT_EN only)
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous, active-low reset
//   req         in   level request per source
//   pattern_in  in   enable mask per source, source i at [i*LED_W +: LED_W]
//   led_enable  out  registered mask to the LED bank, 0 with no owner
//   grant       out  registered one-hot owner, 0 in IDLE/GAP
//   busy        out  high in OWNED or GAP
//   tick        out  prescaler pulse, for observation
//   dbg_state   out  current arbiter state (IDLE=0, OWNED=1, GAP=2)
//
// Requests are plain levels: there is no valid/ready handshake. A source
// holds req high for as long as it wants the bank; dropping req is the only
// way it releases it (apart from preemption and the optional timeout).
//
// Configuration macro LED_ARB_TIMEOUT_EN:
//   defined   - an owner that has held for MAX_HOLD ticks while any other
//               source requests is pushed into GAP and masked out of the next
//               arbitration only, giving rotation even toward lower priority.
//   undefined - no timeout and no mask; a steady high-priority source keeps
//               the bank indefinitely.
// ---------------------------------------------------------------------------
module led_bank_arbiter
  import led_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEFAULT,
  parameter int LED_W       = LED_W_DEFAULT,
  parameter int TICK_DIV    = 10000000,
  parameter int MIN_HOLD    = 4,
  parameter int BLANK_TICKS = 1,
  parameter int MAX_HOLD    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] pattern_in,
  output logic [LED_W-1:0]         led_enable,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     tick,
  output arb_state_e               dbg_state
);

  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // The hold counter must be able to reach both thresholds; past that it
  // simply saturates, which keeps every ">= threshold" test true.
  localparam int HOLD_LIMIT = (MAX_HOLD > MIN_HOLD) ? MAX_HOLD : MIN_HOLD;
  localparam int HOLD_W     = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam int GAP_W      = $clog2(BLANK_TICKS + 1);

  localparam logic [HOLD_W-1:0] MIN_HOLD_C = HOLD_W'(MIN_HOLD);
  localparam logic [GAP_W-1:0]  BLANK_C    = GAP_W'(BLANK_TICKS);
`ifdef LED_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
`endif

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Fixed-priority encoder: returns {found, index of lowest set bit}.
  // Scanning from the top down lets the lowest set index overwrite the rest.
  function automatic logic [IDX_W:0] pick_lowest(input logic [NUM_REQ-1:0] r);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[i]) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  // Loop-based select keeps an out-of-range index from reading past the bus.
  function automatic logic [LED_W-1:0] pattern_of(
    input logic [IDX_W-1:0]         idx,
    input logic [NUM_REQ*LED_W-1:0] pats
  );
    logic [LED_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == idx) p = pats[i*LED_W +: LED_W];
    end
    return p;
  endfunction

  // -------------------------------------------------------------------------
  // Prescaler
  // -------------------------------------------------------------------------
  led_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  arb_state_e        state;
  logic [IDX_W-1:0]  owner;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;
`ifdef LED_ARB_TIMEOUT_EN
  logic [NUM_REQ-1:0] expired_mask;
`endif

  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // Arbitration and exit conditions
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] owner_onehot;
  logic [NUM_REQ-1:0] arb_req;
  logic [IDX_W:0]     pick;
  logic               owner_req;
  logic               higher_req;
  logic               preempt;
  logic               exit_owned;
`ifdef LED_ARB_TIMEOUT_EN
  logic               timeout_exit;
`endif

  always_comb begin
    owner_onehot = onehot(owner);
    owner_req    = |(req & owner_onehot);
    higher_req   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (IDX_W'(i) < owner)) higher_req = 1'b1;
    end
    preempt = higher_req && (hold_cnt >= MIN_HOLD_C);

`ifdef LED_ARB_TIMEOUT_EN
    arb_req = req & ~expired_mask;
    // Timeout only counts as the cause when the owner still wants the bank
    // and nobody is preempting it; otherwise the owner is not masked.
    timeout_exit = owner_req && !preempt && (hold_cnt >= MAX_HOLD_C) &&
                   (|(req & ~owner_onehot));
    exit_owned   = !owner_req || preempt || timeout_exit;
`else
    arb_req    = req;
    exit_owned = !owner_req || preempt;
`endif

    pick = pick_lowest(arb_req);
  end

  // -------------------------------------------------------------------------
  // Arbiter FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      grant      <= '0;
      led_enable <= '0;
      busy       <= 1'b0;
`ifdef LED_ARB_TIMEOUT_EN
      expired_mask <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick[IDX_W]) begin
            state      <= ARB_OWNED;
            owner      <= pick[IDX_W-1:0];
            hold_cnt   <= '0;
            grant      <= onehot(pick[IDX_W-1:0]);
            led_enable <= pattern_of(pick[IDX_W-1:0], pattern_in);
            busy       <= 1'b1;
          end
`ifdef LED_ARB_TIMEOUT_EN
          // The expiry mask lives for exactly one arbitration.
          expired_mask <= '0;
`endif
        end

        ARB_OWNED: begin
          if (exit_owned) begin
            // A tick landing on this edge is deliberately not counted by GAP.
            state      <= ARB_GAP;
            gap_cnt    <= '0;
            grant      <= '0;
            led_enable <= '0;
`ifdef LED_ARB_TIMEOUT_EN
            expired_mask <= timeout_exit ? owner_onehot : '0;
`endif
          end else begin
            led_enable <= pattern_of(owner, pattern_in);
            if (tick && (hold_cnt != '1)) begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end

        ARB_GAP: begin
          if (gap_cnt == BLANK_C) begin
            state <= ARB_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          // Illegal encoding: drop everything and restart from IDLE.
          state      <= ARB_IDLE;
          hold_cnt   <= '0;
          gap_cnt    <= '0;
          grant      <= '0;
          led_enable <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_bank_arbiter
// Self-checking bench for led_bank_arbiter with TICK_DIV=4, MIN_HOLD=2,
// BLANK_TICKS=1, MAX_HOLD=6. A behavioural model (owner index, tick count
// since reset, blank-gap bookkeeping) predicts the outputs; a compare process
// checks them on every falling edge. Directed scenarios add hand-computed
// literal expectations, then a randomized phase runs against the model.
// ---------------------------------------------------------------------------
module tb_led_bank_arbiter;

  localparam int NUM_REQ     = 3;
  localparam int LED_W       = 6;
  localparam int TICK_DIV    = 4;
  localparam int MIN_HOLD    = 2;
  localparam int BLANK_TICKS = 1;
  localparam int MAX_HOLD    = 6;

  // ---------------- clock / reset ----------------
  logic                     clock;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LED_W-1:0] pattern_in;
  logic [LED_W-1:0]         led_enable;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic                     tick;
  logic [1:0]               dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  led_bank_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .LED_W       (LED_W),
    .TICK_DIV    (TICK_DIV),
    .MIN_HOLD    (MIN_HOLD),
    .BLANK_TICKS (BLANK_TICKS),
    .MAX_HOLD    (MAX_HOLD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .pattern_in (pattern_in),
    .led_enable (led_enable),
    .grant      (grant),
    .busy       (busy),
    .tick       (tick),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner is an integer (-1 = none); ticks are derived from the number of
  // rising edges since reset release, not from any DUT counter.
  int               k      = 0;
  int               m_owner = -1;
  bit               m_gap  = 1'b0;
  int               m_hold = 0;
  int               m_gcnt = 0;
  int               m_mask = -1;
  logic [NUM_REQ-1:0] e_grant = '0;
  logic [LED_W-1:0]   e_led   = '0;
  logic               e_busy  = 1'b0;
  logic               e_tick  = 1'b0;
  logic [1:0]         e_state = 2'd0;

  task automatic model_step();
    bit tick_now;
    bit higher;
    bit leave;
`ifdef LED_ARB_TIMEOUT_EN
    bit others;
`endif
    if (!reset) begin
      k = 0; m_owner = -1; m_gap = 1'b0; m_hold = 0; m_gcnt = 0; m_mask = -1;
      e_led = '0;
    end else begin
      tick_now = (k > 0) && (k % TICK_DIV == 0);
      k++;
      if (m_owner >= 0) begin
        higher = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (req[i] && i < m_owner) higher = 1'b1;
        leave = !req[m_owner] || (higher && m_hold >= MIN_HOLD);
`ifdef LED_ARB_TIMEOUT_EN
        others = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (req[i] && i != m_owner) others = 1'b1;
        if (!leave && m_hold >= MAX_HOLD && others) begin
          leave  = 1'b1;
          m_mask = m_owner;
        end
`endif
        if (leave) begin
          m_owner = -1; m_gap = 1'b1; m_gcnt = 0;
        end else begin
          e_led = pattern_in[m_owner*LED_W +: LED_W];
          if (tick_now) m_hold++;
        end
      end else if (m_gap) begin
        if (m_gcnt == BLANK_TICKS) m_gap = 1'b0;
        else if (tick_now) m_gcnt++;
      end else begin
        for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i] && i != m_mask) m_owner = i;
        m_mask = -1;
        if (m_owner >= 0) begin
          m_hold = 0;
          e_led  = pattern_in[m_owner*LED_W +: LED_W];
        end
      end
    end
    if (m_owner < 0) e_led = '0;
    e_grant = (m_owner >= 0) ? NUM_REQ'(1 << m_owner) : '0;
    e_busy  = (m_owner >= 0) || m_gap;
    e_state = (m_owner >= 0) ? 2'd1 : (m_gap ? 2'd2 : 2'd0);
    e_tick  = (k > 0) && (k % TICK_DIV == 0);
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    model_step();
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clock);
    check("grant",      32'(grant),      32'(e_grant));
    check("led_enable", 32'(led_enable), 32'(e_led));
    check("busy",       32'(busy),       32'(e_busy));
    check("tick",       32'(tick),       32'(e_tick));
    check("state",      32'(dbg_state),  32'(e_state));
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after the rising edge, well clear of it.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic set_pat(input int i, input logic [LED_W-1:0] p);
    pattern_in[i*LED_W +: LED_W] = p;
  endtask

  task automatic wait_grant(input logic [NUM_REQ-1:0] g, input int budget, input string name);
    int n;
    n = 0;
    while (grant !== g && n < budget) begin step(1); n++; end
    checks++;
    if (grant !== g) begin
      errors++;
      $display("FAIL %s: grant %b, expected %b within %0d cycles", name, grant, g, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (dbg_state !== 2'd0 && n < budget) begin step(1); n++; end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL %s: state %0d, expected 0 within %0d cycles", name, dbg_state, budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset      = 1'b1;
    req        = 3'b111;
    pattern_in = '0;
    set_pat(0, 6'b110011);
    set_pat(1, 6'b011110);
    #1 reset = 1'b0;

    // 1: reset values with all requests high, then first tick timing
    step(3);
    check("rst_led",   32'(led_enable), 32'h0);
    check("rst_grant", 32'(grant),      32'h0);
    check("rst_busy",  32'(busy),       32'h0);
    check("rst_tick",  32'(tick),       32'h0);
    check("rst_state", 32'(dbg_state),  32'h0);
    reset = 1'b1;
    step(1);
    check("first_grant", 32'(grant),      32'b001);
    check("first_led",   32'(led_enable), 32'b110011);
    req = 3'b000;
    step(2);
    check("tick_edge3", 32'(tick), 32'h0);
    step(1);
    check("tick_edge4", 32'(tick), 32'h1);
    wait_idle(20, "t1_idle");

    // 2: single owner and live pattern edit
    set_pat(2, 6'b101010);
    req = 3'b100;
    step(1);
    check("single_grant", 32'(grant),      32'b100);
    check("single_led",   32'(led_enable), 32'b101010);
    set_pat(2, 6'b000111);
    step(1);
    check("pattern_follow", 32'(led_enable), 32'b000111);

    // 5: asynchronous reset while owned
    reset = 1'b0;
    #1;
    check("areset_led",   32'(led_enable), 32'h0);
    check("areset_grant", 32'(grant),      32'h0);
    check("areset_busy",  32'(busy),       32'h0);
    req = 3'b000;
    step(1);
    reset = 1'b1;

    // 4: owner drops at hold 0
    wait_idle(20, "t4_start");
    req = 3'b010;
    step(1);
    check("drop_grant", 32'(grant), 32'b010);
    req = 3'b000;
    step(1);
    check("drop_gap_grant", 32'(grant),      32'h0);
    check("drop_gap_led",   32'(led_enable), 32'h0);
    check("drop_gap_busy",  32'(busy),       32'h1);
    check("drop_gap_state", 32'(dbg_state),  32'd2);
    wait_idle(12, "drop_idle");
    check("drop_idle_busy", 32'(busy), 32'h0);

    // 3: preemption respects MIN_HOLD
    req = 3'b100;
    step(1);
    check("pre_owner", 32'(grant), 32'b100);
    n = 0;
    while (tick !== 1'b1 && n < 8) begin step(1); n++; end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL pre_tick: tick %b, expected 1 within 8 cycles", tick);
    end
    step(1);
    req = 3'b101;
    step(4);
    check("pre_held",      32'(grant),      32'b100);
    step(1);
    check("pre_blank",     32'(grant),      32'h0);
    check("pre_blank_led", 32'(led_enable), 32'h0);
    step(4);
    check("pre_idle_busy", 32'(busy),       32'h0);
    step(1);
    check("pre_new_owner", 32'(grant),      32'b001);
    req = 3'b000;
    wait_idle(20, "t3_idle");

    // 6: steady high-priority owner against a lower requester
    req = 3'b011;
    step(1);
    check("hold_owner", 32'(grant), 32'b001);
`ifdef LED_ARB_TIMEOUT_EN
    wait_grant(3'b010, 40, "timeout_rotate");
    wait_grant(3'b001, 60, "timeout_return");
`else
    step(60);
    check("no_timeout", 32'(grant), 32'b001);
`endif
    req = 3'b000;
    wait_idle(40, "t6_idle");

    // randomized phase, model-checked every cycle
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 11) == 0) req = NUM_REQ'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) set_pat($urandom_range(0, NUM_REQ - 1), LED_W'($urandom_range(0, 63)));
      if (it == 750) begin
        reset = 1'b0;
        step(1);
        reset = 1'b1;
      end
      step(1);
    end

    req = 3'b000;
    step(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
